// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences the datapath and the shared memory port from FETCH to writeback.
// Optional MCTRL_ILLEGAL_TRAP_EN: unsupported op/funct traps (cause 10) instead of retiring as a NOP.
module mips_multicycle_ctrl #(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_en_o,
  output logic [1:0] pc_source_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic       ext_op_o,
  output logic [2:0] alu_ctrl_o,
  output logic [3:0] state_o,
  output logic       instr_retired_o,
  output logic       trap_o,
  output logic [1:0] trap_cause_o
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEM_ADR = 4'd3,
    S_MEM_RD = 4'd4, S_MEM_WB = 4'd5, S_MEM_WR = 4'd6, S_EXE_R = 4'd7,
    S_WB_R = 4'd8, S_EXE_I = 4'd9, S_WB_I = 4'd10, S_BRANCH = 4'd11,
    S_JUMP = 4'd12, S_TRAP = 4'd15
  } state_e;

  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((WAIT_LIMIT == 0) ? 0 : WAIT_LIMIT - 1);
  localparam bit LIMIT_EN = (WAIT_LIMIT != 0);

  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_OR = 3'b010, ALU_LUI = 3'b011;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cause_q, cause_d;
  logic          pc_write, pc_write_cond, wait_step;

  logic is_lw, is_sw, is_addu, is_subu, is_ori, is_lui, is_beq, is_j;
  assign is_lw   = (op_i == 6'b100011);
  assign is_sw   = (op_i == 6'b101011);
  assign is_addu = (op_i == 6'b000000) && (funct_i == 6'b100001);
  assign is_subu = (op_i == 6'b000000) && (funct_i == 6'b100011);
  assign is_ori  = (op_i == 6'b001101);
  assign is_lui  = (op_i == 6'b001111);
  assign is_beq  = (op_i == 6'b000100);
  assign is_j    = (op_i == 6'b000010);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    cause_d         = cause_q;
    pc_write        = 1'b0;
    pc_write_cond   = 1'b0;
    wait_step       = 1'b0;
    pc_source_o     = 2'b00;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    ext_op_o        = 1'b0;
    alu_ctrl_o      = ALU_ADD;
    instr_retired_o = 1'b0;
    trap_o          = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read_o = 1'b1;
        if (mem_ready_i) begin
          ir_write_o  = 1'b1;
          pc_write    = 1'b1;
          alu_src_b_o = 2'b01;
          state_d     = S_DECODE;
        end else begin
          wait_step = 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_b_o = 2'b11;
        ext_op_o    = 1'b1;
        if (is_lw || is_sw)          state_d = S_MEM_ADR;
        else if (is_addu || is_subu) state_d = S_EXE_R;
        else if (is_ori || is_lui)   state_d = S_EXE_I;
        else if (is_beq)             state_d = S_BRANCH;
        else if (is_j)               state_d = S_JUMP;
        else begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
          cause_d = 2'b10;
`else
          instr_retired_o = 1'b1;
          state_d         = S_FETCH;
`endif
        end
      end
      S_MEM_ADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        ext_op_o    = 1'b1;
        state_d     = is_sw ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        iord_o     = 1'b1;
        mem_read_o = 1'b1;
        if (mem_ready_i) state_d = S_MEM_WB;
        else             wait_step = 1'b1;
      end
      S_MEM_WB: begin
        mem_to_reg_o    = 1'b1;
        reg_write_o     = 1'b1;
        instr_retired_o = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEM_WR: begin
        iord_o      = 1'b1;
        mem_write_o = 1'b1;
        if (mem_ready_i) begin
          instr_retired_o = 1'b1;
          state_d         = S_FETCH;
        end else begin
          wait_step = 1'b1;
        end
      end
      S_EXE_R: begin
        alu_src_a_o = 1'b1;
        alu_ctrl_o  = is_subu ? ALU_SUB : ALU_ADD;
        state_d     = S_WB_R;
      end
      S_WB_R: begin
        reg_dst_o       = 1'b1;
        reg_write_o     = 1'b1;
        instr_retired_o = 1'b1;
        state_d         = S_FETCH;
      end
      S_EXE_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_ctrl_o  = is_lui ? ALU_LUI : ALU_OR;
        state_d     = S_WB_I;
      end
      S_WB_I: begin
        reg_write_o     = 1'b1;
        instr_retired_o = 1'b1;
        state_d         = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_ctrl_o      = ALU_SUB;
        pc_write_cond   = 1'b1;
        pc_source_o     = 2'b01;
        instr_retired_o = 1'b1;
        state_d         = S_FETCH;
      end
      S_JUMP: begin
        pc_write        = 1'b1;
        pc_source_o     = 2'b10;
        instr_retired_o = 1'b1;
        state_d         = S_FETCH;
      end
      S_TRAP: trap_o = 1'b1;
      default: state_d = S_IDLE;
    endcase

    // A ready memory completes the access even on the cycle the limit is reached.
    if (wait_step) begin
      if (LIMIT_EN && (cnt_q == CNT_LAST)) begin
        state_d = S_TRAP;
        cause_d = 2'b01;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    if (state_d != state_q) cnt_d = '0;
  end

  assign pc_en_o      = pc_write | (pc_write_cond & zero_i);
  assign state_o      = state_q;
  assign trap_cause_o = cause_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: instruction-class paths and per-state output table model.
module tb_mips_multicycle_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [5:0] op_i, funct_i;
  logic       zero_i, mem_ready_i;
  logic       pc_en_o, iord_o, mem_read_o, mem_write_o, ir_write_o, reg_dst_o;
  logic       mem_to_reg_o, reg_write_o, alu_src_a_o, ext_op_o, instr_retired_o, trap_o;
  logic [1:0] pc_source_o, alu_src_b_o, trap_cause_o;
  logic [2:0] alu_ctrl_o;
  logic [3:0] state_o;

  int total = 0;
  int bad   = 0;

  localparam int C_ADDU = 0, C_SUBU = 1, C_ORI = 2, C_LUI = 3, C_LW = 4,
                 C_SW = 5, C_BEQ = 6, C_J = 7, C_ILL = 8;

  mips_multicycle_ctrl #(.WAIT_LIMIT(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .op_i(op_i), .funct_i(funct_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i), .pc_en_o(pc_en_o),
    .pc_source_o(pc_source_o), .iord_o(iord_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .ir_write_o(ir_write_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .ext_op_o(ext_op_o),
    .alu_ctrl_o(alu_ctrl_o), .state_o(state_o),
    .instr_retired_o(instr_retired_o), .trap_o(trap_o), .trap_cause_o(trap_cause_o)
  );

  always #5 clk_i = ~clk_i;

  // {mem_read, mem_write, ir_write, iord, reg_write, reg_dst, mem_to_reg, pc_en,
  //  pc_source[2], src_a, src_b[2], ext_op, alu[3], retired, trap}
  function automatic logic [18:0] act_out();
    return {mem_read_o, mem_write_o, ir_write_o, iord_o, reg_write_o, reg_dst_o,
            mem_to_reg_o, pc_en_o, pc_source_o, alu_src_a_o, alu_src_b_o, ext_op_o,
            alu_ctrl_o, instr_retired_o, trap_o};
  endfunction

  function automatic logic [18:0] exp_out(input int s, input logic rdy, input logic z,
                                          input int cls);
    logic mr, mw, irw, iord, rw, rdst, m2r, pcen, sa, ext, ret, trp;
    logic [1:0] pcs, sb;
    logic [2:0] alu;
    {mr, mw, irw, iord, rw, rdst, m2r, pcen, sa, ext, ret, trp} = '0;
    pcs = 2'b00; sb = 2'b00; alu = 3'b000;
    case (s)
      1:  begin mr = 1; if (rdy) begin irw = 1; pcen = 1; sb = 2'b01; end end
      2:  begin
            sb = 2'b11; ext = 1;
`ifndef MCTRL_ILLEGAL_TRAP_EN
            if (cls == C_ILL) ret = 1;
`endif
          end
      3:  begin sa = 1; sb = 2'b10; ext = 1; end
      4:  begin iord = 1; mr = 1; end
      5:  begin m2r = 1; rw = 1; ret = 1; end
      6:  begin iord = 1; mw = 1; ret = rdy; end
      7:  begin sa = 1; alu = (cls == C_SUBU) ? 3'b001 : 3'b000; end
      8:  begin rdst = 1; rw = 1; ret = 1; end
      9:  begin sa = 1; sb = 2'b10; alu = (cls == C_LUI) ? 3'b011 : 3'b010; end
      10: begin rw = 1; ret = 1; end
      11: begin sa = 1; alu = 3'b001; pcs = 2'b01; pcen = z; ret = 1; end
      12: begin pcen = 1; pcs = 2'b10; ret = 1; end
      15: trp = 1;
      default: ;
    endcase
    return {mr, mw, irw, iord, rw, rdst, m2r, pcen, pcs, sa, sb, ext, alu, ret, trp};
  endfunction

  task automatic enc(input int cls, output logic [5:0] op, output logic [5:0] fn);
    fn = 6'($urandom);
    case (cls)
      C_ADDU: begin op = 6'b000000; fn = 6'b100001; end
      C_SUBU: begin op = 6'b000000; fn = 6'b100011; end
      C_ORI:  op = 6'b001101;
      C_LUI:  op = 6'b001111;
      C_LW:   op = 6'b100011;
      C_SW:   op = 6'b101011;
      C_BEQ:  op = 6'b000100;
      C_J:    op = 6'b000010;
      default: begin
        if ($urandom_range(0, 1) == 0) op = 6'b111111;
        else begin op = 6'b000000; fn = 6'b100000; end
      end
    endcase
  endtask

  // fs/ms: stall cycles before mem_ready in FETCH and in the data access.
  task automatic run_instr(input int cls, input int fs, input int ms);
    int path[$];
    logic [5:0] op, fn;
    enc(cls, op, fn);
    case (cls)
      C_ADDU, C_SUBU: path = '{1, 2, 7, 8};
      C_ORI, C_LUI:   path = '{1, 2, 9, 10};
      C_LW:           path = '{1, 2, 3, 4, 5};
      C_SW:           path = '{1, 2, 3, 6};
      C_BEQ:          path = '{1, 2, 11};
      C_J:            path = '{1, 2, 12};
      default:        path = '{1, 2};
    endcase
    foreach (path[k]) begin
      int s, n;
      bit memst;
      s = path[k];
      memst = (s == 1) || (s == 4) || (s == 6);
      n = (s == 1) ? fs : ((s == 4 || s == 6) ? ms : 0);
      for (int i = 0; i <= n; i++) begin
        logic [18:0] e;
        @(negedge clk_i);
        op_i = op; funct_i = fn;
        zero_i = 1'($urandom_range(0, 1));
        mem_ready_i = memst ? (i == n) : 1'($urandom_range(0, 1));
        #1;
        total++;
        if (state_o !== 4'(s)) begin
          bad++;
          $display("FAIL state cls=%0d: got %0d want %0d", cls, state_o, s);
        end
        e = exp_out(s, mem_ready_i, zero_i, cls);
        total++;
        if (act_out() !== e) begin
          bad++;
          $display("FAIL outs cls=%0d st=%0d: got %05h want %05h", cls, s, act_out(), e);
        end
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    total++;
    if ({act_out(), state_o, trap_cause_o} !== '0) begin
      bad++;
      $display("FAIL reset_zero: got %h want 0", {act_out(), state_o, trap_cause_o});
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; op_i = '0; funct_i = '0; zero_i = 0; mem_ready_i = 0;
    #2;
    total++;
    if ({act_out(), state_o, trap_cause_o} !== '0) begin
      bad++;
      $display("FAIL reset_state: got %h want 0", {act_out(), state_o, trap_cause_o});
    end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    total++;
    if (state_o !== 4'd0) begin bad++; $display("FAIL idle: got %0d want 0", state_o); end
    @(negedge clk_i);
    mem_ready_i = 0;
    #1;
    total++;
    if (state_o !== 4'd1 || mem_read_o !== 1'b1) begin
      bad++;
      $display("FAIL fetch_after_reset: got st=%0d mr=%b want st=1 mr=1", state_o, mem_read_o);
    end
  endtask

  task automatic test_directed();
    run_instr(C_ADDU, 0, 0);
    run_instr(C_LW, 0, 3);
    run_instr(C_SW, 1, 2);
    run_instr(C_ORI, 0, 0);
    run_instr(C_LUI, 0, 0);
    run_instr(C_SUBU, 0, 0);
    run_instr(C_J, 0, 0);
    repeat (2) run_instr(C_BEQ, 0, 0);
  endtask

  task automatic test_wait_boundary();
    run_instr(C_ADDU, 15, 0);
    run_instr(C_LW, 0, 15);
    run_instr(C_SW, 15, 15);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int cls;
`ifdef MCTRL_ILLEGAL_TRAP_EN
      cls = $urandom_range(0, 7);
`else
      cls = $urandom_range(0, 8);
`endif
      run_instr(cls, $urandom_range(0, 3), $urandom_range(0, 3));
    end
  endtask

  task automatic test_mid_reset();
    run_instr(C_LW, 0, 0);
    @(negedge clk_i); op_i = 6'b100011; mem_ready_i = 1;
    @(negedge clk_i);
    @(negedge clk_i);
    @(negedge clk_i); mem_ready_i = 0;
    #1;
    total++;
    if (state_o !== 4'd4 || mem_read_o !== 1'b1 || iord_o !== 1'b1) begin
      bad++;
      $display("FAIL mem_rd_hold: got st=%0d mr=%b iord=%b want 4 1 1", state_o, mem_read_o, iord_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    total++;
    if ({act_out(), state_o, trap_cause_o} !== '0) begin
      bad++;
      $display("FAIL mid_reset: got %h want 0", {act_out(), state_o, trap_cause_o});
    end
    @(negedge clk_i); rst_ni = 1'b1;
    @(negedge clk_i); mem_ready_i = 0;
    #1;
    total++;
    if (state_o !== 4'd1 || mem_read_o !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_fetch: got st=%0d mr=%b want 1 1", state_o, mem_read_o);
    end
    run_instr(C_ADDU, 0, 0);
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk_i); mem_ready_i = 0;
      #1;
      total++;
      if (state_o !== 4'd1) begin
        bad++;
        $display("FAIL timeout_wait cyc=%0d: got %0d want 1", i, state_o);
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i); mem_ready_i = 1;
      #1;
      total++;
      if (state_o !== 4'd15 || trap_o !== 1'b1 || trap_cause_o !== 2'b01 ||
          mem_read_o !== 1'b0 || ir_write_o !== 1'b0 || pc_en_o !== 1'b0) begin
        bad++;
        $display("FAIL timeout_trap cyc=%0d: got st=%0d trap=%b cause=%0d want 15 1 1",
                 i, state_o, trap_o, trap_cause_o);
      end
    end
    do_reset();
    run_instr(C_J, 0, 0);
  endtask

  task automatic test_illegal();
`ifdef MCTRL_ILLEGAL_TRAP_EN
    @(negedge clk_i); op_i = 6'b111111; mem_ready_i = 1;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    total++;
    if (state_o !== 4'd15 || trap_o !== 1'b1 || trap_cause_o !== 2'b10) begin
      bad++;
      $display("FAIL illegal_trap: got st=%0d trap=%b cause=%0d want 15 1 2",
               state_o, trap_o, trap_cause_o);
    end
    do_reset();
`else
    run_instr(C_ILL, 0, 0);
    run_instr(C_ILL, 2, 0);
`endif
    run_instr(C_ORI, 0, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_wait_boundary();
    test_random();
    test_mid_reset();
    test_illegal();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
